// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 8-bit CPU fetch stage.
// Holds the default PC geometry and the command-priority encoding used by
// pc_unit to select one action per cycle.
package cpu_pkg;

    localparam int PC_W_DEF     = 8;
    localparam int RESET_PC_DEF = 0;

    // Command encoding, listed in decreasing priority (reset is handled
    // separately because it is a register-level override).
    localparam int CMD_W = 3;
    typedef logic [CMD_W-1:0] cmd_t;

    localparam logic [2:0] CMD_HOLD = 3'd0;
    localparam logic [2:0] CMD_RET  = 3'd1;
    localparam logic [2:0] CMD_CALL = 3'd2;
    localparam logic [2:0] CMD_JMP  = 3'd3;
    localparam logic [2:0] CMD_INC  = 3'd4;

    // Collapse the raw control strobes into the single winning command:
    // stall > ret > call > jump > increment.
    function automatic cmd_t decode_cmd(
        input logic stall,
        input logic ret,
        input logic call,
        input logic jmp
    );
        if (stall) begin
            return CMD_HOLD;
        end else if (ret) begin
            return CMD_RET;
        end else if (call) begin
            return CMD_CALL;
        end else if (jmp) begin
            return CMD_JMP;
        end
        return CMD_INC;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: return-address LIFO used by pc_unit for CALL/RET.
// Storage is addressed by a write pointer that always points at the next
// free slot; the top entry sits one slot below it. Because DEPTH is a power
// of two the pointer wraps naturally, which gives circular overwrite of the
// oldest entry for free when PC_UNIT_RAS_WRAP_EN is defined.
// Build option: PC_UNIT_RAS_WRAP_EN
//   defined   - push when full overwrites the oldest entry, count saturates.
//   undefined - push when full is discarded; no_room_o flags the condition.
module ras_stack import cpu_pkg::*; #(
    parameter  int DEPTH = 4,
    parameter  int W     = PC_W_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,        // synchronous, active-low
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  top_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          no_room_o   // a push issued now would be lost
);

`ifdef PC_UNIT_RAS_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign top_idx   = ptr_q - AW'(1);
    assign top_o     = mem_q[top_idx];
    assign count_o   = count_q;
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign no_room_o = full_o && !WRAP_EN;

    // Pop wins if both are requested; pc_unit never asks for both at once.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !pop_i && !no_room_o;

    // Next pointer/count: pop steps back, push steps forward; in wrap mode
    // a push into a full stack moves the pointer but leaves count saturated.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (do_pop) begin
            ptr_d   = top_idx;
            count_d = count_q - CW'(1);
        end else if (do_push) begin
            ptr_d = ptr_q + AW'(1);
            if (!full_o) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall, absolute jump and
// CALL/RET through an internal return-address stack (ras_stack).
// One command is chosen per cycle by priority reset > stall > ret > call >
// jump > increment; every output is registered.
// Build option: PC_UNIT_RAS_WRAP_EN (forwarded to ras_stack) selects
// circular overwrite instead of dropping a push into a full stack.
module pc_unit import cpu_pkg::*; #(
    parameter  int              PC_W      = PC_W_DEF,
    parameter  logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
    parameter  int              RAS_DEPTH = 4,
    localparam int              CNT_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,          // synchronous, active-low
    input  logic             stall,
    input  logic             pc_write_en,
    input  logic             call,
    input  logic             ret,
    input  logic [PC_W-1:0]  next_pc,
    output logic [PC_W-1:0]  pc_out,
    output logic             ras_empty,
    output logic             ras_full,
    output logic [CNT_W-1:0] ras_count,
    output logic             err
);

    cmd_t            cmd;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic            err_q, err_d;
    logic            ras_push, ras_pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_no_room;

    assign cmd    = decode_cmd(stall, ret, call, pc_write_en);
    // Return address and fall-through both use the modular successor.
    assign pc_inc = pc_q + PC_W'(1);

    assign pc_out = pc_q;
    assign err    = err_q;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push_i    (ras_push),
        .pop_i     (ras_pop),
        .din_i     (pc_inc),
        .top_o     (ras_top),
        .count_o   (ras_count),
        .full_o    (ras_full),
        .empty_o   (ras_empty),
        .no_room_o (ras_no_room)
    );

    // Select next PC, stack action and error flag from the winning command.
    always_comb begin
        pc_d     = pc_q;
        err_d    = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (cmd)
            CMD_HOLD: begin
                pc_d = pc_q;
            end
            CMD_RET: begin
                // A call or jump arriving with ret is dropped and flagged.
                err_d = call || pc_write_en;
                if (!ras_empty) begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end
            CMD_CALL: begin
                // The jump happens even when the return address is lost.
                pc_d     = next_pc;
                ras_push = 1'b1;
                err_d    = ras_no_room;
            end
            CMD_JMP: begin
                pc_d = next_pc;
            end
            CMD_INC: begin
                pc_d = pc_inc;
            end
            default: begin
                pc_d = pc_inc;
            end
        endcase
    end

    // PC and error-pulse registers; reset overrides any command in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit. A driver issues one command per
// cycle and pushes the expected post-edge state, computed by a queue-based
// model of the PC and return stack, into a scoreboard queue; an independent
// monitor pops and compares after every rising edge. Works with or without
// PC_UNIT_RAS_WRAP_EN defined.
module tb_pc_unit;

    localparam int PC_W   = 8;
    localparam int DEPTH  = 4;
    localparam int RST_PC = 0;
    localparam int MOD    = 1 << PC_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            pc_write_en;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] pc_out;
    logic            ras_empty;
    logic            ras_full;
    logic [2:0]      ras_count;
    logic            err;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_W      (PC_W),
        .RESET_PC  (8'h00),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc_write_en (pc_write_en),
        .call        (call),
        .ret         (ret),
        .next_pc     (next_pc),
        .pc_out      (pc_out),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .ras_count   (ras_count),
        .err         (err)
    );

    typedef struct {
        int    pc;
        int    cnt;
        int    empty;
        int    full;
        int    err;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: PC as an integer, stack as a queue (back = top).
    int m_pc;
    int m_ras[$];
    int m_err;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input string tag, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s [%s]: got %0h, expected %0h", name, tag, act, req);
        end
    endfunction

    // Apply the command rules to the model for one clock edge.
    function automatic void model(input bit rst_n, input bit st, input bit rt,
                                  input bit cl, input bit we, input int np);
        int ra;
        m_err = 0;
        if (!rst_n) begin
            m_pc = RST_PC;
            m_ras.delete();
        end else if (st) begin
            m_err = 0;
        end else if (rt) begin
            if (cl || we) m_err = 1;
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = (m_pc + 1) % MOD;
                m_err = 1;
            end
        end else if (cl) begin
            ra   = (m_pc + 1) % MOD;
            m_pc = np;
            if (m_ras.size() < DEPTH) begin
                m_ras.push_back(ra);
            end else begin
`ifdef PC_UNIT_RAS_WRAP_EN
                void'(m_ras.pop_front());
                m_ras.push_back(ra);
`else
                m_err = 1;
`endif
            end
        end else if (we) begin
            m_pc = np;
        end else begin
            m_pc = (m_pc + 1) % MOD;
        end
    endfunction

    // Drive one command for the next rising edge and log its expectation.
    task automatic step(input bit rst_n, input bit st, input bit rt, input bit cl,
                        input bit we, input int np, input string tag);
        exp_t e;
        @(negedge clk);
        rst         = rst_n;
        stall       = st;
        ret         = rt;
        call        = cl;
        pc_write_en = we;
        next_pc     = PC_W'(np);
        model(rst_n, st, rt, cl, we, np % MOD);
        e.pc    = m_pc;
        e.cnt   = m_ras.size();
        e.empty = (m_ras.size() == 0) ? 1 : 0;
        e.full  = (m_ras.size() == DEPTH) ? 1 : 0;
        e.err   = m_err;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT state after each edge that had a command issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_out",    e.tag, int'(pc_out),    e.pc);
                chk("ras_count", e.tag, int'(ras_count), e.cnt);
                chk("ras_empty", e.tag, int'(ras_empty), e.empty);
                chk("ras_full",  e.tag, int'(ras_full),  e.full);
                chk("err",       e.tag, int'(err),       e.err);
                $display("txn %-10s pc=%02h cnt=%0d empty=%0b full=%0b err=%0b",
                         e.tag, pc_out, ras_count, ras_empty, ras_full, err);
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0; stall = 1'b0; ret = 1'b0; call = 1'b0;
        pc_write_en = 1'b0; next_pc = '0;
        m_pc = RST_PC; m_err = 0;

        // Reset then free-run.
        step(0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, "inc");

        // Jump near the top, wrap through zero, then stall.
        step(1, 0, 0, 0, 1, 'hFE, "jmp_fe");
        step(1, 0, 0, 0, 0, 0, "inc_ff");
        step(1, 0, 0, 0, 0, 0, "wrap_00");
        step(1, 1, 0, 0, 0, 0, "stall");
        step(1, 1, 1, 1, 1, 'h77, "stall_cmd");

        // Nested calls and returns.
        step(1, 0, 0, 0, 1, 'h10, "jmp_10");
        step(1, 0, 0, 1, 0, 'h40, "call_40");
        step(1, 0, 0, 0, 0, 0, "inc_41");
        step(1, 0, 0, 1, 1, 'h80, "call_80");
        step(1, 0, 1, 0, 0, 0, "ret_42");
        step(1, 0, 1, 0, 0, 0, "ret_11");

        // Return with an empty stack.
        step(1, 0, 0, 0, 1, 'h20, "jmp_20");
        step(1, 0, 1, 0, 0, 0, "ret_empty");
        step(1, 0, 0, 0, 0, 0, "err_clear");

        // Overfill the stack, then unwind it.
        step(1, 0, 0, 0, 1, 'h50, "jmp_50");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 'h60 + i, "call_fill");
        step(1, 0, 0, 1, 0, 'h90, "call_full");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0, "ret_unwind");

        // Conflicting ret+call, then reset during a call.
        step(1, 0, 0, 0, 1, 'hA4, "jmp_a4");
        step(1, 0, 0, 1, 0, 'h30, "call_30");
        step(1, 0, 1, 1, 0, 'h55, "ret_call");
        step(1, 0, 0, 1, 0, 'h70, "call_70");
        step(0, 0, 0, 1, 0, 'h33, "rst_call");
        step(1, 0, 0, 0, 0, 0, "post_rst");

        // Randomized command mix.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(49) != 0), ($urandom_range(9) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                 ($urandom_range(4) == 0), int'($urandom_range(255)), "rand");
        end

        // Let the monitor drain, bounded.
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the 8-bit CPU. Successor to the plain loadable PC register.
- Adds auto-increment, stall, absolute jump, and CALL/RET through an internal return-address stack (RAS).
- Sits in the fetch stage. pc_out drives instruction-memory address; control decoder drives the command inputs.

Parameters:
- PC_W, 8, width of PC and of every stored return address.
- RESET_PC, 0, value loaded into PC on reset (PC_W bits).
- RAS_DEPTH, 4, number of RAS entries (≥2, power of two).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- stall  input  1  hold PC and RAS unchanged.
- pc_write_en  input  1  absolute jump to next_pc.
- call  input  1  push return address, jump to next_pc.
- ret  input  1  pop RAS into PC.
- next_pc  input  PC_W  jump/call target.
- pc_out  output  PC_W  current PC (registered).
- ras_empty  output  1  RAS holds 0 entries.
- ras_full  output  1  RAS holds RAS_DEPTH entries.
- ras_count  output  $clog2(RAS_DEPTH)+1  entries held.
- err  output  1  one-cycle pulse on illegal/failed operation.

Behaviour:
- All state updates on rising clk; outputs are registered. A command sampled at edge N is visible on pc_out after edge N.
- Reset (rst==0 at edge): pc_out=RESET_PC, ras_count=0, ras_empty=1, ras_full=0, err=0. Reset overrides all other inputs, including mid-call.
- Priority per cycle: reset > stall > ret > call > pc_write_en > increment.
- stall=1: PC, RAS and count held; err=0; all commands ignored.
- ret=1: if not empty, PC<=top entry, count-1. If empty, PC<=pc_out+1, count held, err=1.
- ret=1 together with call or pc_write_en: ret executes; call/jump are dropped; err=1.
- call=1 (no ret): PC<=next_pc. Push (pc_out+1) mod 2^PC_W. When full, see Optional Feature.
- call=1 together with pc_write_en: call executes; no error.
- pc_write_en=1 alone: PC<=next_pc.
- No command: PC<=pc_out+1, wrapping from 2^PC_W-1 to 0 silently.
- err is 0 in every cycle not listed above.
- ras_empty and ras_full are derived from the registered count.

Optional Feature:
- Macro: PC_UNIT_RAS_WRAP_EN.
- Defined: RAS is circular. A call when full overwrites the oldest entry; count stays at RAS_DEPTH; err=0.
- Undefined: a call when full still jumps (PC<=next_pc), but the push is discarded; count held; err=1.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W default;
  - RESET_PC default;
  - the command-priority encoding as localparams (CMD_HOLD, CMD_RET, CMD_CALL, CMD_JMP, CMD_INC).
- One natural sub-module: ras_stack.
  - Parametrised LIFO with push/pop/full/empty/count and the wrap option.
  - pc_unit instantiates it and handles priority plus PC arithmetic.

Test Plan:
- Reset then run: rst=0 one edge, then rst=1 with no commands for 3 edges -> pc_out 00,01,02,03; ras_empty=1.
- Jump, stall and wrap: pc_write_en, next_pc=FE -> pc_out=FE. Next edge -> FF. Next edge -> 00. Then stall=1 for 2 edges -> pc_out stays 00.
- Nested calls and returns: call to 40 from pc 10, then call to 80 from 41 -> ras_count=2. ret -> pc_out=42. ret -> pc_out=11. ras_empty=1, err never set.
- Return on empty RAS: ret at pc 20 with empty RAS -> pc_out=21, err=1 for exactly one cycle.
- Call when full (RAS_DEPTH=4), fifth call to 90 -> pc_out=90.
  - With PC_UNIT_RAS_WRAP_EN: err=0; four rets return the 4 newest addresses.
  - Without the macro: err=1; four rets return the first 4 addresses.
- Conflict and reset mid-operation: ret+call same cycle with 1 entry (A5) -> pc_out=A5, err=1. Then rst=0 during a call -> pc_out=RESET_PC, ras_count=0.
